mem_port_arbiter: RTL

//  Shares one single-port backend memory between pipeline fetch (read-only) and memory stage (read/write).

---
 rtl/mem_port_arbiter.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one single-port backend memory between the fetch port
//            (read-only) and the data port (read/write). One transaction is
//            outstanding at a time. The data port normally wins; a
//            starvation counter forces a pending fetch through after
//            STARVE_LIMIT consecutive data grants. Accesses whose 8-byte
//            span leaves 0..MEM_SIZE-1 are answered with an error and never
//            reach the backend.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            if_*                - fetch request / grant / response
//            dm_*                - data request / grant / response
//            mem_*               - backend command strobe and completion
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int MEM_SIZE     = 1024,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  // fetch port
  input  logic        if_req,
  input  logic [63:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [63:0] if_rdata,
  output logic        if_err,
  // data port
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [63:0] dm_addr,
  input  logic [63:0] dm_wdata,
  output logic        dm_gnt,
  output logic        dm_rvalid,
  output logic [63:0] dm_rdata,
  output logic        dm_err,
  // backend
  output logic        mem_en,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [63:0] mem_rdata
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ISSUE = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_RESP  = 3'd3;
  localparam logic [2:0] ST_ERR   = 3'd4;

  // Highest legal start address: the last byte of the access (addr+7) must
  // still be inside the array.
  localparam logic [63:0] LAST_ADDR = 64'(MEM_SIZE - 8);
  localparam logic [3:0]  LIMIT     = 4'(STARVE_LIMIT);

  logic [2:0]  state;
  logic [2:0]  state_nxt;
  logic        owner_data;   // 1: data port owns the transaction, 0: fetch
  logic [63:0] txn_addr;
  logic [63:0] txn_wdata;
  logic        txn_we;
  logic [3:0]  starve_cnt;

  logic any_req;
  logic fetch_wins;
  logic addr_ok;

  assign any_req    = if_req | dm_req;
  assign fetch_wins = if_req & (~dm_req | (starve_cnt == LIMIT));
  assign addr_ok    = (txn_addr <= LAST_ADDR);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (any_req) state_nxt = ST_ISSUE;
      ST_ISSUE: state_nxt = addr_ok ? ST_WAIT : ST_ERR;
      ST_WAIT:  if (mem_rvalid) state_nxt = ST_RESP;
      ST_RESP:  state_nxt = ST_IDLE;
      ST_ERR:   state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Transaction latch, starvation counter and held read data
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_data <= 1'b0;
      txn_addr   <= '0;
      txn_wdata  <= '0;
      txn_we     <= 1'b0;
      starve_cnt <= '0;
      if_rdata   <= '0;
      dm_rdata   <= '0;
    end else begin
      if (state == ST_IDLE) begin
        if (any_req) begin
          owner_data <= ~fetch_wins;
          txn_addr   <= fetch_wins ? if_addr : dm_addr;
          txn_we     <= ~fetch_wins & dm_we;
          txn_wdata  <= fetch_wins ? '0 : dm_wdata;
        end
        // A pending fetch that loses can only lose to the data port, so this
        // is exactly "data granted while fetch waits".
        if (if_req && !fetch_wins) begin
          starve_cnt <= (starve_cnt == LIMIT) ? starve_cnt : starve_cnt + 4'd1;
        end else begin
          starve_cnt <= '0;
        end
      end

      // rdata registers feed the ports directly, so they are loaded on the
      // edge that enters RESP/ERR and then hold until the next response.
      if (state == ST_WAIT && mem_rvalid) begin
        if (owner_data) begin
          dm_rdata <= txn_we ? '0 : mem_rdata;
        end else begin
          if_rdata <= mem_rdata;
        end
      end

      if (state == ST_ISSUE && !addr_ok) begin
        if (owner_data) begin
          dm_rdata <= '0;
        end else begin
          if_rdata <= '0;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output decode
  // --------------------------------------------------------------------------
  always_comb begin
    if_gnt    = 1'b0;
    dm_gnt    = 1'b0;
    if_rvalid = 1'b0;
    dm_rvalid = 1'b0;
    if_err    = 1'b0;
    dm_err    = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      ST_ISSUE: begin
        if_gnt = ~owner_data;
        dm_gnt = owner_data;
        if (addr_ok) begin
          mem_en    = 1'b1;
          mem_we    = txn_we;
          mem_addr  = txn_addr;
          mem_wdata = txn_wdata;
        end
      end
      ST_RESP: begin
        if_rvalid = ~owner_data;
        dm_rvalid = owner_data;
      end
      ST_ERR: begin
        if_rvalid = ~owner_data;
        dm_rvalid = owner_data;
        if_err    = ~owner_data;
        dm_err    = owner_data;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire
